// File: rtl/nios2_debug_mem_sequencer_pkg.sv
// Shared definitions for the debug memory sequencer: FSM state encoding,
// bit positions inside the 38-bit debug shift word, and the helper that
// sizes the transaction timeout counter.
package nios2_debug_mem_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } state_e;

  localparam int JDO_W         = 38;
  localparam int JDO_ADDR_LSB  = 17;
  localparam int JDO_RDEN_BIT  = 34;
  localparam int JDO_WDATA_LSB = 3;

  // Counter only has to hold TIMEOUT-1, so clog2(TIMEOUT) bits suffice.
  function automatic int tmo_cnt_width(input int timeout);
    return (timeout <= 2) ? 1 : $clog2(timeout);
  endfunction

endpackage

// File: rtl/nios2_debug_mem_timeout.sv
// Loadable down-counter guarding one memory transaction. Loaded with
// TIMEOUT-1 when a transaction starts, it counts down while enabled and
// flags expiry during the cycle in which it sits at zero.
module nios2_debug_mem_timeout #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         expire_o
);

  logic [W-1:0] count_q;

  // Load on transaction start, otherwise count down until zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_q <= count_q - W'(1);
    end
  end

  assign expire_o = en_i && (count_q == '0);

endmodule

// File: rtl/nios2_debug_mem_sequencer.sv
// Debug-side master of the OCI memory port. Converts debug-slave action
// strobes plus the jdo word into single-word reads/writes, auto-increments
// the debug address and reports results via MonDReg / monitor_ready /
// monitor_error.
// Optional build macro: DEBUG_MEM_PROTECT_EN -- when defined, writes at or
// above PROT_BASE are refused without touching memory.
module nios2_debug_mem_sequencer
  import nios2_debug_mem_sequencer_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 64
`ifdef DEBUG_MEM_PROTECT_EN
  , parameter logic [ADDR_W-1:0] PROT_BASE = ADDR_W'(8'hE0)
`endif
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [JDO_W-1:0]  jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  output logic              busy,
  output logic              overrun
);

  localparam int CNT_W = tmo_cnt_width(TIMEOUT);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         mondreg_q, mondreg_d;
  logic                req_q, req_d;
  logic                ready_q, ready_d;
  logic                error_q, error_d;
  logic                overrun_q, overrun_d;
  logic                tmo_load;
  logic                tmo_expire;
  logic                any_strobe;

  // Only the address, read-enable and write-data fields are meaningful here.
  logic unused_jdo;
  assign unused_jdo = ^{jdo[JDO_W-1:JDO_RDEN_BIT+1], jdo[JDO_WDATA_LSB-1:0]};

  assign any_strobe = take_action_ocimem_a | take_action_ocimem_b |
                      take_no_action_ocimem_a;

  nios2_debug_mem_timeout #(
    .W (CNT_W)
  ) u_timeout (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_i     (tmo_load),
    .load_val_i (CNT_W'(TIMEOUT - 1)),
    .en_i       (state_q != ST_IDLE),
    .expire_o   (tmo_expire)
  );

  // Next-state logic: strobe decode in IDLE, ack/timeout handling in RD/WR.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    mondreg_d = mondreg_q;
    req_d     = req_q;
    ready_d   = ready_q;
    error_d   = error_q;
    overrun_d = overrun_q;
    tmo_load  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (take_action_ocimem_a) begin
          // Address load always wins and is the only way to clear overrun.
          ready_d   = 1'b0;
          error_d   = 1'b0;
          overrun_d = 1'b0;
          addr_d    = jdo[JDO_ADDR_LSB +: ADDR_W];
          if (jdo[JDO_RDEN_BIT]) begin
            state_d  = ST_RD;
            req_d    = 1'b1;
            tmo_load = 1'b1;
          end
        end else if (take_action_ocimem_b) begin
          ready_d = 1'b0;
          error_d = 1'b0;
          wdata_d = jdo[JDO_WDATA_LSB +: 32];
`ifdef DEBUG_MEM_PROTECT_EN
          if (addr_q >= PROT_BASE) begin
            // Refused write completes immediately as an error but still
            // advances the address so block transfers stay in step.
            ready_d = 1'b1;
            error_d = 1'b1;
            addr_d  = addr_q + ADDR_W'(1);
          end else begin
            state_d  = ST_WR;
            req_d    = 1'b1;
            tmo_load = 1'b1;
          end
`else
          state_d  = ST_WR;
          req_d    = 1'b1;
          tmo_load = 1'b1;
`endif
        end else if (take_no_action_ocimem_a) begin
          ready_d  = 1'b0;
          error_d  = 1'b0;
          state_d  = ST_RD;
          req_d    = 1'b1;
          tmo_load = 1'b1;
        end
      end

      ST_RD, ST_WR: begin
        if (any_strobe) begin
          overrun_d = 1'b1;
        end
        // Ack is checked first so it beats a timeout landing the same cycle.
        if (mem_ack) begin
          if (state_q == ST_RD) begin
            mondreg_d = mem_rdata;
          end
          addr_d  = addr_q + ADDR_W'(1);
          req_d   = 1'b0;
          ready_d = 1'b1;
          state_d = ST_IDLE;
        end else if (tmo_expire) begin
          req_d   = 1'b0;
          ready_d = 1'b1;
          error_d = 1'b1;
          state_d = ST_IDLE;
        end
      end

      default: begin
        req_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; async reset drops mem_req immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      mondreg_q <= '0;
      req_q     <= 1'b0;
      ready_q   <= 1'b0;
      error_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      mondreg_q <= mondreg_d;
      req_q     <= req_d;
      ready_q   <= ready_d;
      error_q   <= error_d;
      overrun_q <= overrun_d;
    end
  end

  assign mem_req       = req_q;
  assign mem_we        = (state_q == ST_WR);
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign MonDReg       = mondreg_q;
  assign monitor_ready = ready_q;
  assign monitor_error = error_q;
  assign busy          = (state_q != ST_IDLE);
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_nios2_debug_mem_sequencer.sv
// Directed bench for nios2_debug_mem_sequencer: a cycle-by-cycle vector
// table for the basic read/write/priority behaviour, then hand-written
// sequences for timeout, overrun, reset and the optional write protection.
`timescale 1ns/1ps
module tb_nios2_debug_mem_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [37:0] jdo = '0;
  logic        ta_a = 1'b0, tna_a = 1'b0, ta_b = 1'b0;
  logic        mem_req, mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata, MonDReg;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        monitor_ready, monitor_error, busy, overrun;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  nios2_debug_mem_sequencer dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (ta_a),
    .take_no_action_ocimem_a (tna_a),
    .take_action_ocimem_b    (ta_b),
    .mem_req                 (mem_req),
    .mem_we                  (mem_we),
    .mem_addr                (mem_addr),
    .mem_wdata               (mem_wdata),
    .mem_rdata               (mem_rdata),
    .mem_ack                 (mem_ack),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error),
    .busy                    (busy),
    .overrun                 (overrun)
  );

  typedef struct {
    logic        a, b, n;
    logic [37:0] jdo;
    logic        ack;
    logic [31:0] rdata;
    logic        e_req, e_we;
    logic [7:0]  e_addr;
    logic        e_wchk;
    logic [31:0] e_wdata;
    logic        e_ready, e_err, e_busy, e_ovr;
    logic [31:0] e_mond;
  } vec_t;

  vec_t vecs [15];

  function automatic logic [37:0] ja(input logic [7:0] ad, input logic rd);
    logic [37:0] j;
    j = '0;
    j[34] = rd;
    j[24:17] = ad;
    return j;
  endfunction

  function automatic logic [37:0] jb(input logic [31:0] d);
    logic [37:0] j;
    j = '0;
    j[34:3] = d;
    return j;
  endfunction

  function automatic vec_t mk(input logic a, b, n, input logic [37:0] j,
                              input logic ack, input logic [31:0] rd,
                              input logic req, we, input logic [7:0] ad,
                              input logic wchk, input logic [31:0] wd,
                              input logic rdy, err, bsy, ovr,
                              input logic [31:0] mond);
    vec_t v;
    v.a = a; v.b = b; v.n = n; v.jdo = j; v.ack = ack; v.rdata = rd;
    v.e_req = req; v.e_we = we; v.e_addr = ad; v.e_wchk = wchk;
    v.e_wdata = wd; v.e_ready = rdy; v.e_err = err; v.e_busy = bsy;
    v.e_ovr = ovr; v.e_mond = mond;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive(input logic a, b, n, input logic [37:0] j,
                       input logic ack, input logic [31:0] rd);
    ta_a = a; ta_b = b; tna_a = n; jdo = j; mem_ack = ack; mem_rdata = rd;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cyc;

    // in: a b n jdo ack rdata | exp: req we addr wchk wdata rdy err busy ovr mond
    vecs[0]  = mk(1,0,0, ja(8'h10,1), 0, 0,            1,0,8'h10, 0,0,            0,0,1,0, 32'h0);
    vecs[1]  = mk(0,0,0, '0,          0, 0,            1,0,8'h10, 0,0,            0,0,1,0, 32'h0);
    vecs[2]  = mk(0,0,0, '0,          1, 32'hDEADBEEF, 0,0,8'h11, 0,0,            1,0,0,0, 32'hDEADBEEF);
    vecs[3]  = mk(1,0,0, ja(8'hFF,0), 0, 0,            0,0,8'hFF, 0,0,            0,0,0,0, 32'hDEADBEEF);
    vecs[4]  = mk(0,1,0, jb(32'h1),   0, 0,            1,1,8'hFF, 1,32'h1,        0,0,1,0, 32'hDEADBEEF);
    vecs[5]  = mk(0,0,0, '0,          1, 32'h55,       0,0,8'h00, 1,32'h1,        1,0,0,0, 32'hDEADBEEF);
    vecs[6]  = mk(0,1,0, jb(32'h2),   0, 0,            1,1,8'h00, 1,32'h2,        0,0,1,0, 32'hDEADBEEF);
    vecs[7]  = mk(0,0,0, '0,          1, 0,            0,0,8'h01, 1,32'h2,        1,0,0,0, 32'hDEADBEEF);
    vecs[8]  = mk(1,1,0, ja(8'h40,0), 0, 0,            0,0,8'h40, 0,0,            0,0,0,0, 32'hDEADBEEF);
    vecs[9]  = mk(0,0,0, '0,          0, 0,            0,0,8'h40, 0,0,            0,0,0,0, 32'hDEADBEEF);
    vecs[10] = mk(0,0,0, '0,          1, 32'h12345678, 0,0,8'h40, 0,0,            0,0,0,0, 32'hDEADBEEF);
    vecs[11] = mk(0,0,1, '0,          0, 0,            1,0,8'h40, 0,0,            0,0,1,0, 32'hDEADBEEF);
    vecs[12] = mk(0,0,0, '0,          1, 32'hCAFEF00D, 0,0,8'h41, 0,0,            1,0,0,0, 32'hCAFEF00D);
    vecs[13] = mk(0,1,1, jb(32'hA5A5A5A5), 0, 0,       1,1,8'h41, 1,32'hA5A5A5A5, 0,0,1,0, 32'hCAFEF00D);
    vecs[14] = mk(0,0,0, '0,          1, 0,            0,0,8'h42, 0,0,            1,0,0,0, 32'hCAFEF00D);

    // Reset state
    repeat (3) tick();
    chk("rst.req", 32'(mem_req), 0);
    chk("rst.ready", 32'(monitor_ready), 0);
    chk("rst.error", 32'(monitor_error), 0);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.addr", 32'(mem_addr), 0);
    chk("rst.mond", MonDReg, 0);
    reset_n = 1'b1;
    tick();

    // Vector table
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].a, vecs[i].b, vecs[i].n, vecs[i].jdo, vecs[i].ack, vecs[i].rdata);
      tick();
      chk($sformatf("v%0d.req", i), 32'(mem_req), 32'(vecs[i].e_req));
      chk($sformatf("v%0d.we", i), 32'(mem_we), 32'(vecs[i].e_we));
      chk($sformatf("v%0d.addr", i), 32'(mem_addr), 32'(vecs[i].e_addr));
      if (vecs[i].e_wchk) chk($sformatf("v%0d.wdata", i), mem_wdata, vecs[i].e_wdata);
      chk($sformatf("v%0d.ready", i), 32'(monitor_ready), 32'(vecs[i].e_ready));
      chk($sformatf("v%0d.error", i), 32'(monitor_error), 32'(vecs[i].e_err));
      chk($sformatf("v%0d.busy", i), 32'(busy), 32'(vecs[i].e_busy));
      chk($sformatf("v%0d.overrun", i), 32'(overrun), 32'(vecs[i].e_ovr));
      chk($sformatf("v%0d.mond", i), MonDReg, vecs[i].e_mond);
      $display("vector %0d: req=%0b we=%0b addr=%h rdy=%0b err=%0b mond=%h",
               i, mem_req, mem_we, mem_addr, monitor_ready, monitor_error, MonDReg);
    end

    // Timeout: read at 0x20 with no ack, mem_req must last exactly 64 cycles
    drive(1, 0, 0, ja(8'h20, 0), 0, 0); tick();
    drive(0, 0, 1, '0, 0, 0); tick();
    idle();
    cyc = 0;
    while (mem_req && cyc < 200) begin
      cyc++;
      tick();
    end
    chk("tmo.req_cycles", 32'(cyc), 64);
    chk("tmo.ready", 32'(monitor_ready), 1);
    chk("tmo.error", 32'(monitor_error), 1);
    chk("tmo.addr", 32'(mem_addr), 32'h20);
    chk("tmo.mond", MonDReg, 32'hCAFEF00D);
    chk("tmo.busy", 32'(busy), 0);
    $display("timeout read: req cycles=%0d err=%0b", cyc, monitor_error);

    // Ack arriving in the final timeout cycle wins
    drive(0, 0, 1, '0, 0, 0); tick();
    idle();
    repeat (63) tick();
    chk("ackwin.req_held", 32'(mem_req), 1);
    drive(0, 0, 0, '0, 1, 32'h0BADF00D); tick(); idle();
    chk("ackwin.error", 32'(monitor_error), 0);
    chk("ackwin.ready", 32'(monitor_ready), 1);
    chk("ackwin.mond", MonDReg, 32'h0BADF00D);
    chk("ackwin.addr", 32'(mem_addr), 32'h21);
    $display("ack-at-timeout read: err=%0b mond=%h", monitor_error, MonDReg);

    // Overrun: strobe while busy is ignored and sticky until an address load
    drive(0, 0, 1, '0, 0, 0); tick();
    drive(0, 0, 1, '0, 0, 0); tick();
    chk("ovr.set", 32'(overrun), 1);
    chk("ovr.req", 32'(mem_req), 1);
    chk("ovr.addr", 32'(mem_addr), 32'h21);
    drive(0, 0, 0, '0, 1, 32'h11112222); tick();
    chk("ovr.addr_after", 32'(mem_addr), 32'h22);
    chk("ovr.mond", MonDReg, 32'h11112222);
    chk("ovr.busy_after", 32'(busy), 0);
    drive(0, 0, 1, '0, 0, 0); tick();
    drive(0, 0, 0, '0, 1, 32'h0); tick();
    chk("ovr.sticky", 32'(overrun), 1);
    drive(1, 0, 0, ja(8'h30, 0), 0, 0); tick(); idle();
    chk("ovr.cleared", 32'(overrun), 0);
    chk("ovr.load_addr", 32'(mem_addr), 32'h30);
    $display("overrun sequence: overrun=%0b addr=%h", overrun, mem_addr);

    // Reset mid-transaction drops mem_req without waiting for a clock
    drive(0, 0, 1, '0, 0, 0); tick(); idle();
    chk("arst.req_before", 32'(mem_req), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst.req", 32'(mem_req), 0);
    chk("arst.busy", 32'(busy), 0);
    chk("arst.addr", 32'(mem_addr), 0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    $display("async reset mid-read: req=%0b", mem_req);

    // Write to 0xE5: refused when protection is built in, issued otherwise
    drive(1, 0, 0, ja(8'hE5, 0), 0, 0); tick();
    drive(0, 1, 0, jb(32'h77), 0, 0); tick(); idle();
`ifdef DEBUG_MEM_PROTECT_EN
    chk("prot.req", 32'(mem_req), 0);
    chk("prot.ready", 32'(monitor_ready), 1);
    chk("prot.error", 32'(monitor_error), 1);
    chk("prot.addr", 32'(mem_addr), 32'hE6);
    chk("prot.busy", 32'(busy), 0);
`else
    chk("wrE5.req", 32'(mem_req), 1);
    chk("wrE5.we", 32'(mem_we), 1);
    chk("wrE5.wdata", mem_wdata, 32'h77);
    drive(0, 0, 0, '0, 1, 0); tick(); idle();
    chk("wrE5.error", 32'(monitor_error), 0);
    chk("wrE5.addr", 32'(mem_addr), 32'hE6);
`endif
    $display("write 0xE5: err=%0b addr=%h", monitor_error, mem_addr);

    // Read of 0xE5 always succeeds
    drive(1, 0, 0, ja(8'hE5, 1), 0, 0); tick(); idle();
    chk("rdE5.req", 32'(mem_req), 1);
    chk("rdE5.addr", 32'(mem_addr), 32'hE5);
    drive(0, 0, 0, '0, 1, 32'h600DCAFE); tick(); idle();
    chk("rdE5.error", 32'(monitor_error), 0);
    chk("rdE5.ready", 32'(monitor_ready), 1);
    chk("rdE5.mond", MonDReg, 32'h600DCAFE);
    $display("read 0xE5: err=%0b mond=%h", monitor_error, MonDReg);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
